// File: rtl/bitwise_unit_arbiter_if.sv
// Request/response channel between one requester and the shared bitwise unit.
// The requester drives the op and operands and accepts the result; the unit
// drives ready, rsp_valid and the result.
interface bitwise_unit_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  // Request side
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  // Response side
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] f;

  // Requester view
  modport master (
    output valid,
    output op,
    output x,
    output y,
    output rsp_ready,
    input  ready,
    input  rsp_valid,
    input  f
  );

  // Arbiter view
  modport slave (
    input  valid,
    input  op,
    input  x,
    input  y,
    input  rsp_ready,
    output ready,
    output rsp_valid,
    output f
  );
endinterface

// File: rtl/bitwise_unit_arbiter.sv
// Time-shares one WIDTH-bit AND/OR/XOR/NOR unit between requesters A and B.
// Round-robin arbitration in IDLE, one EXEC cycle, then RESP until the owner
// takes the result. Only one op is ever in flight.
module bitwise_unit_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_unit_arbiter_if.slave a,
  bitwise_unit_arbiter_if.slave b,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic OwnerA = 1'b0;
  localparam logic OwnerB = 1'b1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] a_f_q, b_f_q;
  logic [WIDTH-1:0] result;
  logic             grant_a, grant_b;
  logic             latch_en, a_f_en, b_f_en;
  logic             owner_rsp_ready;

  // Round-robin grant, offered only while idle; the loser of a tie is the
  // requester that was served last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == StIdle) begin
      if (a.valid && b.valid) begin
        grant_a = (last_grant_q == OwnerB);
        grant_b = (last_grant_q == OwnerA);
      end else begin
        grant_a = a.valid;
        grant_b = b.valid;
      end
    end
  end

  // Shared bitwise datapath working on the latched operands.
  always_comb begin
    result = '0;
    unique case (op_q)
      2'b00: result = x_q & y_q;
      2'b01: result = x_q | y_q;
      2'b10: result = x_q ^ y_q;
      2'b11: result = ~(x_q | y_q);
    endcase
  end

  // Sequencer next state, operand capture and result write enables.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    latch_en        = 1'b0;
    a_f_en          = 1'b0;
    b_f_en          = 1'b0;
    owner_rsp_ready = (owner_q == OwnerA) ? a.rsp_ready : b.rsp_ready;
    unique case (state_q)
      StIdle: begin
        if (grant_a || grant_b) begin
          latch_en = 1'b1;
          owner_d  = grant_b ? OwnerB : OwnerA;
          state_d  = StExec;
        end
      end
      StExec: begin
        a_f_en  = (owner_q == OwnerA);
        b_f_en  = (owner_q == OwnerB);
        state_d = StResp;
      end
      StResp: begin
        // Pointer moves on completion only, so an aborted op never counts.
        if (owner_rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state and arbitration pointer; reset prefers A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnerA;
      last_grant_q <= OwnerB;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Capture the granted requester's op and operands on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 2'b00;
      x_q  <= '0;
      y_q  <= '0;
    end else if (latch_en) begin
      op_q <= grant_b ? b.op : a.op;
      x_q  <= grant_b ? b.x  : a.x;
      y_q  <= grant_b ? b.y  : a.y;
    end
  end

  // Per-requester result registers; each keeps its last delivered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_f_q <= '0;
      b_f_q <= '0;
    end else begin
      if (a_f_en) a_f_q <= result;
      if (b_f_en) b_f_q <= result;
    end
  end

  assign a.ready     = grant_a;
  assign b.ready     = grant_b;
  assign a.rsp_valid = (state_q == StResp) && (owner_q == OwnerA);
  assign b.rsp_valid = (state_q == StResp) && (owner_q == OwnerB);
  assign a.f         = a_f_q;
  assign b.f         = b_f_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Scoreboard bench: issue tasks push expected results, a negedge monitor pops
// and compares on each response handshake and checks hold/fairness rules.
module tb_bitwise_unit_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  logic busy8;

  bitwise_unit_arbiter_if #(.WIDTH(32)) a_if ();
  bitwise_unit_arbiter_if #(.WIDTH(32)) b_if ();
  bitwise_unit_arbiter_if #(.WIDTH(8))  n_a ();
  bitwise_unit_arbiter_if #(.WIDTH(8))  n_b ();

  bitwise_unit_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_if),
    .b     (b_if),
    .busy  (busy)
  );

  bitwise_unit_arbiter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (n_a),
    .b     (n_b),
    .busy  (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          grant_log[$];
  bit          model_last = 1'b1;  // 1 = B served last, so A is preferred
  bit          held_v[2];
  logic [31:0] held_f[2];
  int          hs_cyc[2];
  int          acc_cyc_a, acc_cyc_b;
  bit          rand_rsp = 1'b0;

  // Reference: per-bit truth table indexed by {x,y}
  function automatic logic [31:0] ref_f(input int w, input logic [1:0] op,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [3:0]  tt;
    logic [31:0] r;
    case (op)
      2'd0:    tt = 4'b1000;
      2'd1:    tt = 4'b1110;
      2'd2:    tt = 4'b0110;
      default: tt = 4'b0001;
    endcase
    r = '0;
    for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue_a(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int waited);
    bit got = 1'b0;
    waited = 0;
    a_if.valid = 1'b1; a_if.op = op; a_if.x = x; a_if.y = y;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      waited++;
      if (a_if.ready) got = 1'b1;
    end
    if (got) begin
      qa.push_back(ref_f(32, op, x, y));
      acc_cyc_a = cyc;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL accept_a: no a_ready after %0d cycles, expected a grant", waited);
    end
    @(posedge clk); #1;
    a_if.valid = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int waited);
    bit got = 1'b0;
    waited = 0;
    b_if.valid = 1'b1; b_if.op = op; b_if.x = x; b_if.y = y;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      waited++;
      if (b_if.ready) got = 1'b1;
    end
    if (got) begin
      qb.push_back(ref_f(32, op, x, y));
      acc_cyc_b = cyc;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL accept_b: no b_ready after %0d cycles, expected a grant", waited);
    end
    @(posedge clk); #1;
    b_if.valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL drain: pending a=%0d b=%0d busy=%0b, expected all delivered",
               qa.size(), qb.size(), busy);
    end
  endtask

  // Monitor for one response channel
  task automatic mon_side(input int s, input logic v, input logic r, input logic [31:0] f);
    logic [31:0] exp;
    string       nm = (s == 0) ? "A" : "B";
    if (held_v[s]) begin
      n_tests++;
      if (v !== 1'b1 || f !== held_f[s]) begin
        n_fail++;
        $display("FAIL rsp_hold_%s: valid=%b f=%h, expected valid=1 f=%h", nm, v, f, held_f[s]);
      end
    end
    if (v === 1'b1 && r === 1'b1) begin
      n_tests++;
      if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
        n_fail++;
        $display("FAIL rsp_%s: unexpected response f=%h, expected none", nm, f);
      end else begin
        exp = (s == 0) ? qa.pop_front() : qb.pop_front();
        if (f !== exp) begin
          n_fail++;
          $display("FAIL rsp_%s: f=%h, expected %h", nm, f, exp);
        end
      end
      hs_cyc[s]  = cyc;
      model_last = (s == 1);
    end
    held_v[s] = (v === 1'b1) && (r !== 1'b1);
    held_f[s] = f;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_side(0, a_if.rsp_valid, a_if.rsp_ready, a_if.f);
      mon_side(1, b_if.rsp_valid, b_if.rsp_ready, b_if.f);
      if (a_if.rsp_valid && b_if.rsp_valid) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_excl: both rsp_valid high, expected at most one");
      end
      if (a_if.ready && b_if.ready) begin
        n_tests++; n_fail++;
        $display("FAIL grant_excl: both ready high, expected at most one");
      end
      if (a_if.valid && b_if.valid && (a_if.ready || b_if.ready)) begin
        n_tests++;
        if (b_if.ready !== !model_last) begin
          n_fail++;
          $display("FAIL fairness: granted %s, expected %s",
                   b_if.ready ? "B" : "A", model_last ? "A" : "B");
        end
      end
      if (a_if.ready) grant_log.push_back(1'b0);
      if (b_if.ready) grant_log.push_back(1'b1);
    end
  end

  // Reset discards anything in flight
  always @(negedge rst_n) begin
    qa.delete();
    qb.delete();
    grant_log.delete();
    model_last = 1'b1;
    held_v[0]  = 1'b0;
    held_v[1]  = 1'b0;
  end

  // Random response back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rsp) begin
        a_if.rsp_ready = ($urandom_range(0, 9) < 7);
        b_if.rsp_ready = ($urandom_range(0, 9) < 7);
      end
    end
  end

  task automatic rand_a(input int nops);
    int          w;
    logic [1:0]  op;
    logic [31:0] x, y;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      op = 2'($urandom_range(0, 3)); x = $urandom; y = $urandom;
      issue_a(op, x, y, w);
    end
  endtask

  task automatic rand_b(input int nops);
    int          w;
    logic [1:0]  op;
    logic [31:0] x, y;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      op = 2'($urandom_range(0, 3)); x = $urandom; y = $urandom;
      issue_b(op, x, y, w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    bit          got;
    logic [31:0] seq;
    logic [31:0] exp_b[4];
    logic [1:0]  op8;
    logic [7:0]  x8, y8;

    exp_b[0] = 32'h0000_00FF; exp_b[1] = 32'h00FF_FFFF;
    exp_b[2] = 32'h00FF_FF00; exp_b[3] = 32'hFF00_0000;

    rst_n = 1'b0;
    a_if.valid = 1'b0; a_if.op = 2'b00; a_if.x = '0; a_if.y = '0; a_if.rsp_ready = 1'b1;
    b_if.valid = 1'b0; b_if.op = 2'b00; b_if.x = '0; b_if.y = '0; b_if.rsp_ready = 1'b1;
    n_a.valid = 1'b0; n_a.op = 2'b00; n_a.x = '0; n_a.y = '0; n_a.rsp_ready = 1'b1;
    n_b.valid = 1'b0; n_b.op = 2'b00; n_b.x = '0; n_b.y = '0; n_b.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_ready", 32'(a_if.ready), 0);
    chk("rst_b_ready", 32'(b_if.ready), 0);
    chk("rst_a_rsp_valid", 32'(a_if.rsp_valid), 0);
    chk("rst_b_rsp_valid", 32'(b_if.rsp_valid), 0);
    chk("rst_a_f", a_if.f, 0);
    chk("rst_b_f", b_if.f, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // A only: latency and result
    issue_a(2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
    chk("a_ready_cycle0", 32'(w), 1);
    @(negedge clk);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rsp_valid", 32'(a_if.rsp_valid), 0);
    @(negedge clk);
    chk("resp_rsp_valid", 32'(a_if.rsp_valid), 1);
    chk("resp_busy", 32'(busy), 1);
    chk("resp_a_f", a_if.f, 32'hF000_F000);
    @(negedge clk);
    chk("after_hs_busy", 32'(busy), 0);
    @(posedge clk); #1;

    // B only, every opcode; b_f holds after handshake
    for (int op = 0; op < 4; op++) begin
      issue_b(2'(op), 32'h0000_FFFF, 32'h00FF_00FF, w);
      wait_idle();
      chk($sformatf("b_op%0d_f", op), b_if.f, exp_b[op]);
      @(posedge clk); #1;
    end

    // Both valid continuously: alternating grants
    grant_log.delete();
    fork
      begin
        issue_a(2'b10, 32'h1234_5678, 32'h0F0F_0F0F, w);
        issue_a(2'b01, 32'hDEAD_0000, 32'h0000_BEEF, w);
      end
      begin
        issue_b(2'b00, 32'hCAFE_F00D, 32'hFFFF_0000, w);
        issue_b(2'b11, 32'h0101_0101, 32'h8080_8080, w);
      end
    join
    wait_idle();
    seq = '0;
    foreach (grant_log[i]) seq = {seq[30:0], grant_log[i]};
    chk("rr_count", 32'(grant_log.size()), 4);
    chk("rr_order", seq, 32'b0101);
    @(posedge clk); #1;

    // Response back-pressure on A while B waits
    a_if.rsp_ready = 1'b0;
    fork
      issue_a(2'b01, 32'hAAAA_0000, 32'h0000_5555, w);
      begin
        @(posedge clk); #1;
        issue_b(2'b10, 32'h3333_3333, 32'h5555_5555, w);
      end
      begin
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
          @(negedge clk);
          if (a_if.rsp_valid) got = 1'b1;
        end
        chk("bp_rsp_seen", 32'(got), 1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_rsp_valid", 32'(a_if.rsp_valid), 1);
          chk("bp_b_ready", 32'(b_if.ready), 0);
          chk("bp_busy", 32'(busy), 1);
        end
        @(posedge clk); #1;
        a_if.rsp_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_b_first_idle", 32'(acc_cyc_b), 32'(hs_cyc[0] + 1));
    @(posedge clk); #1;

    // Reset during EXEC: A served last, so only reset makes A preferred again
    issue_a(2'b01, 32'h0F00_0000, 32'h0000_00F0, w);
    wait_idle();
    @(posedge clk); #1;
    issue_a(2'b10, 32'hFFFF_FFFF, 32'h0000_0001, w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_a_rsp_valid", 32'(a_if.rsp_valid), 0);
    chk("mid_rst_a_f", a_if.f, 0);
    chk("mid_rst_b_f", b_if.f, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'({a_if.rsp_valid, b_if.rsp_valid}), 0);
    end
    @(posedge clk); #1;
    fork
      issue_a(2'b00, 32'h1111_1111, 32'h0101_0101, w);
      issue_b(2'b01, 32'h2222_0000, 32'h0000_2222, w);
    join
    wait_idle();
    seq = '0;
    foreach (grant_log[i]) seq = {seq[30:0], grant_log[i]};
    chk("post_rst_count", 32'(grant_log.size()), 2);
    chk("post_rst_order", seq, 32'b01);
    @(posedge clk); #1;

    // Random traffic with random back-pressure
    rand_rsp = 1'b1;
    fork
      rand_a(15);
      rand_b(15);
    join
    rand_rsp = 1'b0;
    @(posedge clk); #1;
    a_if.rsp_ready = 1'b1;
    b_if.rsp_ready = 1'b1;
    wait_idle();
    chk("rand_qa_empty", 32'(qa.size()), 0);
    chk("rand_qb_empty", 32'(qb.size()), 0);
    @(posedge clk); #1;

    // WIDTH=8 instance: two directed ops then a few random ones
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin op8 = 2'b00; x8 = 8'hA5; y8 = 8'h3C; end
      else if (i == 1) begin op8 = 2'b11; x8 = 8'h00; y8 = 8'h00; end
      else begin op8 = 2'($urandom_range(0, 3)); x8 = 8'($urandom); y8 = 8'($urandom); end
      n_a.valid = 1'b1; n_a.op = op8; n_a.x = x8; n_a.y = y8;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (n_a.ready) got = 1'b1;
      end
      chk("w8_accept", 32'(got), 1);
      @(posedge clk); #1;
      n_a.valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (n_a.rsp_valid) got = 1'b1;
      end
      chk($sformatf("w8_f_%0d", i), {24'h0, n_a.f}, ref_f(8, op8, {24'h0, x8}, {24'h0, y8}));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
